// File: rtl/jtag_host_driver.sv
// Bit-level JTAG initiator: shifts up to MaxLen TMS/TDI bits per command and
// returns the TDO bits captured on each TCK rising edge.
module jtag_host_driver #(
    parameter int unsigned ClkDiv = 4,
    parameter int unsigned MaxLen = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_trst_i,
    input  logic [5:0]        cmd_len_i,
    input  logic [MaxLen-1:0] cmd_tms_i,
    input  logic [MaxLen-1:0] cmd_tdi_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [MaxLen-1:0] rsp_tdo_o,
    output logic              busy_o,
    output logic              jtag_tck_o,
    output logic              jtag_tms_o,
    output logic              jtag_tdi_o,
    output logic              jtag_trst_no,
    input  logic              jtag_tdo_i
);

    localparam int unsigned DivW    = $clog2(ClkDiv + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(ClkDiv - 1);
    localparam logic [5:0]  LenMax  = 6'(MaxLen);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_TRST,
        S_RESP
    } state_t;

    state_t            state_q;
    logic [DivW-1:0]   div_q;
    logic [5:0]        idx_q;
    logic [5:0]        len_q;
    logic              half_q;
    logic [MaxLen-1:0] tms_sh_q;
    logic [MaxLen-1:0] tdi_sh_q;

    logic [5:0]        len_clamp_c;
    logic [5:0]        idx_next_c;
    logic              div_done_c;
    logic [MaxLen-1:0] tdo_bit_c;

    // Clamp requested length, end-of-half-period flag and the TDO capture bit.
    always_comb begin
        len_clamp_c = (cmd_len_i > LenMax) ? LenMax : cmd_len_i;
        idx_next_c  = idx_q + 6'd1;
        div_done_c  = (div_q == DivLast);
        tdo_bit_c   = MaxLen'(jtag_tdo_i) << idx_q;
    end

    // Command FSM with all pin and handshake outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            idx_q        <= '0;
            len_q        <= '0;
            half_q       <= 1'b0;
            tms_sh_q     <= '0;
            tdi_sh_q     <= '0;
            cmd_ready_o  <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_tdo_o    <= '0;
            busy_o       <= 1'b0;
            jtag_tck_o   <= 1'b0;
            jtag_tms_o   <= 1'b1;
            jtag_tdi_o   <= 1'b0;
            jtag_trst_no <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cmd_ready_o  <= 1'b1;
                    jtag_trst_no <= 1'b1;
                    jtag_tck_o   <= 1'b0;
                    if (cmd_valid_i && cmd_ready_o) begin
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        rsp_tdo_o   <= '0;
                        div_q       <= '0;
                        idx_q       <= '0;
                        half_q      <= 1'b0;
                        if (cmd_trst_i) begin
                            state_q      <= S_TRST;
                            jtag_trst_no <= 1'b0;
                        end else if (len_clamp_c == 6'd0) begin
                            state_q     <= S_RESP;
                            rsp_valid_o <= 1'b1;
                        end else begin
                            state_q    <= S_LOW;
                            len_q      <= len_clamp_c;
                            jtag_tms_o <= cmd_tms_i[0];
                            jtag_tdi_o <= cmd_tdi_i[0];
                            tms_sh_q   <= cmd_tms_i >> 1;
                            tdi_sh_q   <= cmd_tdi_i >> 1;
                        end
                    end
                end
                S_LOW: begin
                    if (div_done_c) begin
                        state_q    <= S_HIGH;
                        div_q      <= '0;
                        jtag_tck_o <= 1'b1;
                        rsp_tdo_o  <= rsp_tdo_o | tdo_bit_c;
                    end else begin
                        div_q <= div_q + DivW'(1);
                    end
                end
                S_HIGH: begin
                    if (div_done_c) begin
                        div_q      <= '0;
                        jtag_tck_o <= 1'b0;
                        idx_q      <= idx_next_c;
                        if (idx_next_c == len_q) begin
                            state_q     <= S_RESP;
                            rsp_valid_o <= 1'b1;
                        end else begin
                            state_q    <= S_LOW;
                            jtag_tms_o <= tms_sh_q[0];
                            jtag_tdi_o <= tdi_sh_q[0];
                            tms_sh_q   <= tms_sh_q >> 1;
                            tdi_sh_q   <= tdi_sh_q >> 1;
                        end
                    end else begin
                        div_q <= div_q + DivW'(1);
                    end
                end
                S_TRST: begin
                    // Two divider periods of TRSTn low, tracked by half_q.
                    if (div_done_c) begin
                        div_q <= '0;
                        if (half_q) begin
                            state_q      <= S_RESP;
                            rsp_valid_o  <= 1'b1;
                            jtag_trst_no <= 1'b1;
                        end else begin
                            half_q <= 1'b1;
                        end
                    end else begin
                        div_q <= div_q + DivW'(1);
                    end
                end
                S_RESP: begin
                    jtag_tck_o <= 1'b0;
                    if (rsp_ready_i) begin
                        state_q     <= S_IDLE;
                        rsp_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        cmd_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_host_driver.sv
// Self-checking bench for jtag_host_driver: loopback, TAP IDCODE read, edges,
// back-pressure and reset behaviour.
module tb_jtag_host_driver;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned MAX_LEN = 32;
    localparam logic [31:0] IDCODE  = 32'h1D00_5A3B;

    // TAP controller states
    localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7;
    localparam int UDR = 8, SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_trst;
    logic [5:0]        cmd_len;
    logic [MAX_LEN-1:0] cmd_tms;
    logic [MAX_LEN-1:0] cmd_tdi;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [MAX_LEN-1:0] rsp_tdo;
    logic              busy;
    logic              jtag_tck;
    logic              jtag_tms;
    logic              jtag_tdi;
    logic              jtag_trst_n;
    logic              jtag_tdo;

    logic              tap_mode;
    logic              tap_tdo;
    int                tap_st;
    logic [31:0]       tap_sr;

    int                errors = 0;
    int                checks = 0;
    int unsigned       cyc = 0;

    int                rises = 0;
    int                hi_run = 0;
    int                hi_bad = 0;
    int                trst_run = 0;
    int                last_trst_len = 0;
    logic              tck_prev = 1'b0;
    logic              trst_prev = 1'b1;

    jtag_host_driver #(.ClkDiv(CLK_DIV), .MaxLen(MAX_LEN)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_trst_i   (cmd_trst),
        .cmd_len_i    (cmd_len),
        .cmd_tms_i    (cmd_tms),
        .cmd_tdi_i    (cmd_tdi),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_tdo_o    (rsp_tdo),
        .busy_o       (busy),
        .jtag_tck_o   (jtag_tck),
        .jtag_tms_o   (jtag_tms),
        .jtag_tdi_o   (jtag_tdi),
        .jtag_trst_no (jtag_trst_n),
        .jtag_tdo_i   (jtag_tdo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    assign jtag_tdo = tap_mode ? tap_tdo : jtag_tdi;

    // Behavioural IEEE 1149.1 TAP with only an IDCODE data register.
    function automatic int tap_next(input int s, input logic tms);
        case (s)
            TLR:  return tms ? TLR  : RTI;
            RTI:  return tms ? SDR  : RTI;
            SDR:  return tms ? SIR  : CDR;
            CDR:  return tms ? E1DR : SHDR;
            SHDR: return tms ? E1DR : SHDR;
            E1DR: return tms ? UDR  : PDR;
            PDR:  return tms ? E2DR : PDR;
            E2DR: return tms ? UDR  : SHDR;
            UDR:  return tms ? SDR  : RTI;
            SIR:  return tms ? TLR  : CIR;
            CIR:  return tms ? E1IR : SHIR;
            SHIR: return tms ? E1IR : SHIR;
            E1IR: return tms ? UIR  : PIR;
            PIR:  return tms ? E2IR : PIR;
            E2IR: return tms ? UIR  : SHIR;
            default: return tms ? SDR : RTI;
        endcase
    endfunction

    always @(posedge jtag_tck or negedge jtag_trst_n) begin
        if (jtag_trst_n === 1'b0) begin
            tap_st <= TLR;
        end else begin
            if (tap_st == CDR)  tap_sr <= IDCODE;
            if (tap_st == SHDR) tap_sr <= {jtag_tdi, tap_sr[31:1]};
            tap_st <= tap_next(tap_st, jtag_tms);
        end
    end

    assign tap_tdo = (tap_st == SHDR) ? tap_sr[0] : 1'b0;

    // Pin monitor: TCK rising edges, TCK high widths, TRSTn low widths.
    always @(negedge clk) begin
        if (jtag_tck === 1'b1) begin
            if (tck_prev !== 1'b1) rises++;
            hi_run++;
        end else begin
            if (tck_prev === 1'b1 && hi_run != int'(CLK_DIV)) hi_bad++;
            hi_run = 0;
        end
        tck_prev = jtag_tck;
        if (jtag_trst_n === 1'b0) begin
            trst_run++;
        end else begin
            if (trst_prev === 1'b0) last_trst_len = trst_run;
            trst_run = 0;
        end
        trst_prev = jtag_trst_n;
    end

    function automatic logic [31:0] len_mask(input int n);
        logic [31:0] m;
        for (int i = 0; i < 32; i++) m[i] = (i < n);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command, optionally stall the response, then complete the handshake.
    task automatic run_cmd(input logic trst, input logic [5:0] len, input logic [31:0] tms,
                           input logic [31:0] tdi, input int hold,
                           output logic [31:0] tdo, output int lat, output int pulses);
        int t0;
        int r0;
        int n;
        cmd_valid = 1'b1;
        cmd_trst  = trst;
        cmd_len   = len;
        cmd_tms   = tms;
        cmd_tdi   = tdi;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_seen", 64'(cmd_ready), 64'd1);
        t0 = int'(cyc);
        r0 = rises;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_trst  = 1'($urandom);
        cmd_len   = 6'($urandom);
        cmd_tms   = $urandom;
        cmd_tdi   = $urandom;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_valid_seen", 64'(rsp_valid), 64'd1);
        lat    = int'(cyc) - t0;
        tdo    = rsp_tdo;
        pulses = rises - r0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_tdo",   64'(rsp_tdo),   64'(tdo));
            chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("bp_tck",       64'(jtag_tck),  64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_hs_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("post_hs_cmd_ready", 64'(cmd_ready), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tck"},       64'(jtag_tck),    64'd0);
        chk({tag, "_tms"},       64'(jtag_tms),    64'd1);
        chk({tag, "_tdi"},       64'(jtag_tdi),    64'd0);
        chk({tag, "_trst_n"},    64'(jtag_trst_n), 64'd0);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready),   64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid),   64'd0);
        chk({tag, "_rsp_tdo"},   64'(rsp_tdo),     64'd0);
        chk({tag, "_busy"},      64'(busy),        64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] tdo;
        logic [31:0] tdi;
        logic [5:0]  len;
        int          lat;
        int          pulses;
        int          eff;
        int          r0;
        int          n;
        int          seen;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_trst  = 1'b0;
        cmd_len   = '0;
        cmd_tms   = '0;
        cmd_tdi   = '0;
        rsp_ready = 1'b0;
        tap_mode  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);
        chk("por_release_trst_n", 64'(jtag_trst_n), 64'd1);
        chk("por_release_ready",  64'(cmd_ready),   64'd1);

        // Loopback, 8 bits of 0xA5.
        run_cmd(1'b0, 6'd8, 32'h0, 32'hA5, 0, tdo, lat, pulses);
        chk("lb8_tdo",     64'(tdo),    64'h0000_00A5);
        chk("lb8_latency", 64'(lat),    64'(1 + 2 * CLK_DIV * 8));
        chk("lb8_pulses",  64'(pulses), 64'd8);
        chk("lb8_tdi_hold", 64'(jtag_tdi), 64'd1);
        chk("lb8_tck_high", 64'(hi_bad), 64'd0);

        // Reset held 3 cycles while idle.
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rst_release_trst_n", 64'(jtag_trst_n), 64'd1);
        chk("idle_rst_release_ready",  64'(cmd_ready),   64'd1);

        // Zero-length command.
        run_cmd(1'b0, 6'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, tdo, lat, pulses);
        chk("len0_tdo",     64'(tdo),    64'd0);
        chk("len0_latency", 64'(lat),    64'd1);
        chk("len0_pulses",  64'(pulses), 64'd0);

        // Over-length command clamps to 32 bits.
        tdi = $urandom;
        run_cmd(1'b0, 6'd40, 32'h0, tdi, 0, tdo, lat, pulses);
        chk("len40_tdo",     64'(tdo),    64'(tdi));
        chk("len40_latency", 64'(lat),    64'(1 + 2 * CLK_DIV * 32));
        chk("len40_pulses",  64'(pulses), 64'd32);

        // Random loopback commands.
        for (int k = 0; k < 6; k++) begin
            len = 6'($urandom_range(1, 32));
            tdi = $urandom;
            eff = int'(len);
            run_cmd(1'b0, len, $urandom, tdi, 0, tdo, lat, pulses);
            chk("rnd_tdo",     64'(tdo),    64'(tdi & len_mask(eff)));
            chk("rnd_latency", 64'(lat),    64'(1 + 2 * CLK_DIV * eff));
            chk("rnd_pulses",  64'(pulses), 64'(eff));
        end
        chk("rnd_tck_high", 64'(hi_bad), 64'd0);

        // TRST pulse command.
        run_cmd(1'b1, 6'd12, 32'hFFF, 32'hFFF, 0, tdo, lat, pulses);
        chk("trst_tdo",     64'(tdo),           64'd0);
        chk("trst_latency", 64'(lat),           64'(1 + 2 * CLK_DIV));
        chk("trst_pulses",  64'(pulses),        64'd0);
        chk("trst_low_len", 64'(last_trst_len), 64'(2 * CLK_DIV));

        // Back-pressure on the response.
        tdi = $urandom;
        run_cmd(1'b0, 6'd16, 32'h0, tdi, 10, tdo, lat, pulses);
        chk("bp_tdo", 64'(tdo), 64'(tdi & 32'h0000_FFFF));

        // TAP reset, walk to Shift-DR, then read IDCODE.
        tap_mode = 1'b1;
        run_cmd(1'b0, 6'd5, 32'h1F, 32'h0, 0, tdo, lat, pulses);
        chk("tap_reset_pulses", 64'(pulses), 64'd5);
        run_cmd(1'b0, 6'd4, 32'h2, 32'h0, 0, tdo, lat, pulses);
        run_cmd(1'b0, 6'd32, 32'h0, $urandom, 0, tdo, lat, pulses);
        chk("tap_idcode", 64'(tdo), 64'(IDCODE));
        tap_mode = 1'b0;

        // Reset after 3 of 8 bits.
        cmd_valid = 1'b1;
        cmd_trst  = 1'b0;
        cmd_len   = 6'd8;
        cmd_tms   = 32'h0;
        cmd_tdi   = 32'h3C;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        r0 = rises;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (rises - r0 < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_bit3", 64'(rises - r0), 64'd3);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort_rst");
        r0 = rises;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        chk("abort_no_rsp",    64'(seen),       64'd0);
        chk("abort_no_edges",  64'(rises - r0), 64'd0);
        run_cmd(1'b0, 6'd8, 32'h0, 32'h3C, 0, tdo, lat, pulses);
        chk("after_abort_tdo",     64'(tdo),    64'h3C);
        chk("after_abort_latency", 64'(lat),    64'(1 + 2 * CLK_DIV * 8));
        chk("after_abort_pulses",  64'(pulses), 64'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
